// File: rtl/cs_channel_arbiter.sv
// Round-robin arbiter sharing one CS (series-approximation) datapath across NCH sample windows.
// Optional CS_WARMUP_MASK_EN suppresses each channel's results until its 9-deep window is full.
module cs_channel_arbiter #(
    parameter int unsigned NCH = 4,
    localparam int unsigned CHW = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req,
    input  logic [NCH*8-1:0] x_in,
    input  logic [NCH-1:0]   clr,
    output logic [NCH-1:0]   gnt,
    output logic [9:0]       y_out,
    output logic [CHW-1:0]   y_ch,
    output logic             y_valid
);

    logic [7:0]     win_q [NCH][9];
    logic [7:0]     win_d [NCH][9];
    logic [10:0]    sum_q [NCH];
    logic [10:0]    sum_d [NCH];
    logic [CHW-1:0] ptr_q, ptr_d;
    logic           s1_vld_q, s1_vld_d;
    logic [CHW-1:0] s1_ch_q, s1_ch_d;
    logic [9:0]     y_out_q, y_out_d;
    logic [CHW-1:0] y_ch_q, y_ch_d;
    logic           y_valid_q, y_valid_d;

    logic [NCH-1:0] elig;
    logic           gnt_any;
    logic [CHW-1:0] gnt_idx;
    logic [10:0]    sum_s;
    logic [10:0]    avg;
    logic [7:0]     xappr;
    logic           mask;

    // clr beats req; nothing is granted while reset is asserted
    assign elig = reset ? '0 : (req & ~clr);

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!gnt_any && elig[CHW'((int'(ptr_q) + i) % NCH)]) begin
                gnt_any = 1'b1;
                gnt_idx = CHW'((int'(ptr_q) + i) % NCH);
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
        ptr_d = ptr_q;
        if (gnt_any) ptr_d = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_comb begin
        win_d = win_q;
        sum_d = sum_q;
        for (int k = 0; k < NCH; k++) begin
            if (clr[k]) begin
                for (int j = 0; j < 9; j++) win_d[k][j] = '0;
                sum_d[k] = '0;
            end else if (gnt[k]) begin
                for (int j = 8; j > 0; j--) win_d[k][j] = win_q[k][j-1];
                win_d[k][0] = x_in[8*k +: 8];
                sum_d[k] = sum_q[k] - {3'b000, win_q[k][8]} + {3'b000, x_in[8*k +: 8]};
            end
        end
        s1_vld_d = gnt_any;
        s1_ch_d  = gnt_any ? gnt_idx : s1_ch_q;
    end

    // Shared stage reads the window as it stands before the edge, so a clr in
    // this cycle does not disturb the in-flight result.
    always_comb begin
        sum_s = sum_q[s1_ch_q];
        avg   = sum_s / 11'd9;
        xappr = '0;
        for (int j = 0; j < 9; j++) begin
            if ({3'b000, win_q[s1_ch_q][j]} <= avg && win_q[s1_ch_q][j] > xappr) begin
                xappr = win_q[s1_ch_q][j];
            end
        end
        y_out_d   = 10'((13'(sum_s) + 13'(xappr) * 13'd9) >> 3);
        y_ch_d    = s1_ch_q;
        y_valid_d = s1_vld_q & mask;
    end

`ifdef CS_WARMUP_MASK_EN
    logic [3:0] fill_q [NCH];
    logic [3:0] fill_d [NCH];

    always_comb begin
        fill_d = fill_q;
        for (int k = 0; k < NCH; k++) begin
            if (clr[k]) fill_d[k] = '0;
            else if (gnt[k] && fill_q[k] != 4'd9) fill_d[k] = fill_q[k] + 4'd1;
        end
        mask = (fill_q[s1_ch_q] == 4'd9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) fill_q[k] <= '0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    assign mask = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                sum_q[k] <= '0;
                for (int j = 0; j < 9; j++) win_q[k][j] <= '0;
            end
            ptr_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_ch_q   <= '0;
            y_out_q   <= '0;
            y_ch_q    <= '0;
            y_valid_q <= 1'b0;
        end else begin
            win_q     <= win_d;
            sum_q     <= sum_d;
            ptr_q     <= ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_ch_q   <= s1_ch_d;
            y_out_q   <= y_out_d;
            y_ch_q    <= y_ch_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_ch    = y_ch_q;
    assign y_valid = y_valid_q;

endmodule

// File: tb/tb_cs_channel_arbiter.sv
// Directed bench for cs_channel_arbiter: a round-robin vector table plus hand-written
// sequences for warm-up, clear and mid-run reset.
module tb_cs_channel_arbiter;

`ifdef CS_WARMUP_MASK_EN
    localparam bit MASKED = 1'b1;
`else
    localparam bit MASKED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] x_in = '0;
    logic [3:0]  clr = '0;
    logic [3:0]  gnt;
    logic [9:0]  y_out;
    logic [1:0]  y_ch;
    logic        y_valid;

    int checks = 0;
    int errors = 0;

    cs_channel_arbiter #(.NCH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .x_in    (x_in),
        .clr     (clr),
        .gnt     (gnt),
        .y_out   (y_out),
        .y_ch    (y_ch),
        .y_valid (y_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic       vld;
        logic [9:0] y;
        logic [1:0] ch;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        clr   = '0;
        x_in  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_result(input string name, input bit vld, input int y, input int ch);
        chk({name, "_valid"}, int'(y_valid), int'(vld));
        if (vld) begin
            chk({name, "_y"}, int'(y_out), y);
            chk({name, "_ch"}, int'(y_ch), ch);
        end
    endtask

    initial begin
        // x_k = 8*(k+1): single-sample Y = x>>3, two-sample Y = 2x>>3 (Xappr = 0 both times)
        tbl[0] = '{4'b1111, 4'b0001, 1'b0, 10'd0, 2'd0};
        tbl[1] = '{4'b1111, 4'b0010, 1'b0, 10'd0, 2'd0};
        tbl[2] = '{4'b1111, 4'b0100, 1'b1, 10'd1, 2'd0};
        tbl[3] = '{4'b1111, 4'b1000, 1'b1, 10'd2, 2'd1};
        tbl[4] = '{4'b1111, 4'b0001, 1'b1, 10'd3, 2'd2};
        tbl[5] = '{4'b1111, 4'b0010, 1'b1, 10'd4, 2'd3};
        tbl[6] = '{4'b1111, 4'b0100, 1'b1, 10'd2, 2'd0};
        tbl[7] = '{4'b1111, 4'b1000, 1'b1, 10'd4, 2'd1};
        tbl[8] = '{4'b0000, 4'b0000, 1'b1, 10'd6, 2'd2};
        tbl[9] = '{4'b0000, 4'b0000, 1'b1, 10'd8, 2'd3};

        // Reset state, and no grant while reset is high
        req = 4'b1111;
        tick();
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_valid", int'(y_valid), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_ych", int'(y_ch), 0);
        req = '0;
        tick();
        reset = 1'b0;

        // Round-robin with all channels requesting
        x_in = {8'd32, 8'd24, 8'd16, 8'd8};
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            #1;
            chk($sformatf("rr_gnt%0d", i), int'(gnt), int'(tbl[i].gnt));
            chk_result($sformatf("rr%0d", i), tbl[i].vld && !MASKED, int'(tbl[i].y),
                       int'(tbl[i].ch));
            tick();
        end

        // Reset mid-run: ptr sits at 3 and ch0 holds data when reset hits
        req = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        #1;
        chk("midrst_gnt", int'(gnt), 0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_valid", int'(y_valid), 0);
        x_in = {8'd32, 8'd24, 8'd16, 8'd40};
        chk("midrst_first_gnt", int'(gnt), 1);
        tick();
        req = '0;
        tick();
        chk_result("midrst_res", !MASKED, 5, 0);

        // Nine samples of 100 on ch0
        do_reset();
        x_in = 32'd100;
        req  = 4'b0001;
        for (int n = 0; n < 9; n++) begin
            #1;
            chk($sformatf("t1_gnt%0d", n), int'(gnt), 1);
            tick();
        end
        req = '0;
        tick();
        chk_result("t1_res", 1'b1, 225, 0);
        tick();
        chk("t1_pulse", int'(y_valid), 0);

        // ch1 fed 1..9
        do_reset();
        req = 4'b0010;
        for (int n = 1; n <= 9; n++) begin
            x_in = {16'd0, 8'(n), 8'd0};
            #1;
            chk($sformatf("t2_gnt%0d", n), int'(gnt), 2);
            tick();
        end
        req = '0;
        tick();
        chk_result("t2_res", 1'b1, 11, 1);

        // Single sample of 72 on ch0
        do_reset();
        x_in = 32'd72;
        req  = 4'b0001;
        tick();
        req = '0;
        tick();
        chk("t3_valid", int'(y_valid), int'(!MASKED));
        if (!MASKED) begin
            chk("t3_y", int'(y_out), 9);
            chk("t3_ch", int'(y_ch), 0);
        end

        // Clear on ch2 beats its request, then ch2 restarts from an empty window
        do_reset();
        x_in = {8'd0, 8'd200, 16'd0};
        req  = 4'b0100;
        tick();
        tick();
        x_in = {8'd0, 8'd50, 16'd0};
        req  = 4'b0101;
        clr  = 4'b0100;
        #1;
        chk("t5_clr_gnt", int'(gnt), 1);
        tick();
        clr = '0;
        for (int j = 0; j < 9; j++) begin
            req = (j == 0) ? 4'b0101 : 4'b0100;
            #1;
            chk($sformatf("t5_gnt%0d", j), int'(gnt), 4);
            tick();
            if (j == 1) chk_result("t5_first", !MASKED, 6, 2);
        end
        req = '0;
        tick();
        chk_result("t5_res", 1'b1, 112, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
